// File: rtl/lc3_pkg.sv
// Shared LC3 types and constants used by the execute, controller and writeback blocks.
package lc3_pkg;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_idx_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC   = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  localparam logic [2:0] PSR_N = 3'b100;
  localparam logic [2:0] PSR_Z = 3'b010;
  localparam logic [2:0] PSR_P = 3'b001;

endpackage

// File: rtl/lc3_reg_file.sv
// General register file: one synchronous write port, two asynchronous read ports,
// asynchronous active-low clear.
module lc3_reg_file #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // No write-through: a same-cycle read sees the pre-edge contents.
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: selects the result source, writes the register file
// and tracks the NZP status of the last written value.
module lc3_writeback
  import lc3_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [1:0]        W_Control_in,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] memout,
  input  logic [ADDR_W-1:0] dr,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2,
  output logic [2:0]        psr
);

  function automatic logic [2:0] nzp_of(input logic signed [DATA_W-1:0] v);
    if (v < 0)       return PSR_N;
    else if (v == 0) return PSR_Z;
    else             return PSR_P;
  endfunction

  wb_sel_e             wb_sel;
  logic [DATA_W-1:0]   dr_in;
  logic                wr_en;

  assign wb_sel = wb_sel_e'(W_Control_in);

  always_comb begin
    dr_in = aluout;
    case (wb_sel)
      WB_ALU:  dr_in = aluout;
      WB_MEM:  dr_in = memout;
      WB_PC:   dr_in = pcout;
      default: dr_in = aluout;
    endcase
  end

  // The reserved select suppresses both the register write and the PSR update.
  assign wr_en = enable_writeback && (wb_sel != WB_RSVD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     psr <= 3'b000;
    else if (wr_en) psr <= nzp_of(dr_in);
  end

  lc3_reg_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (wr_en),
    .waddr  (dr),
    .wdata  (dr_in),
    .raddr1 (sr1),
    .raddr2 (sr2),
    .rdata1 (VSR1),
    .rdata2 (VSR2)
  );

endmodule

// File: tb/tb_lc3_writeback.sv
// Scoreboard bench for lc3_writeback: stimulus queues expected read-port/PSR values,
// a negedge monitor pops and compares them.
module tb_lc3_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_writeback;
  logic [1:0]  W_Control_in;
  logic [15:0] aluout, pcout, memout;
  logic [2:0]  dr, sr1, sr2;
  logic [15:0] VSR1, VSR2;
  logic [2:0]  psr;

  typedef struct {
    string       name;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [2:0]  p;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  lc3_writeback dut (
    .clk              (clk),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .W_Control_in     (W_Control_in),
    .aluout           (aluout),
    .pcout            (pcout),
    .memout           (memout),
    .dr               (dr),
    .sr1              (sr1),
    .sr2              (sr2),
    .VSR1             (VSR1),
    .VSR2             (VSR2),
    .psr              (psr)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are sampled on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (VSR1 !== e.v1 || VSR2 !== e.v2 || psr !== e.p) begin
        n_bad++;
        $display("FAIL %s: got VSR1=%h VSR2=%h psr=%b, expected VSR1=%h VSR2=%h psr=%b",
                 e.name, VSR1, VSR2, psr, e.v1, e.v2, e.p);
      end
    end
  end

  task automatic check(input string name, input logic [2:0] a, input logic [2:0] b,
                       input logic [15:0] e1, input logic [15:0] e2, input logic [2:0] ep);
    exp_t e;
    sr1 = a;
    sr2 = b;
    e.name = name; e.v1 = e1; e.v2 = e2; e.p = ep;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] m,
                          input logic [15:0] p, input logic [2:0] d);
    enable_writeback = 1'b1;
    W_Control_in = sel;
    aluout = a; memout = m; pcout = p; dr = d;
    @(posedge clk); #1;
    enable_writeback = 1'b0;
    W_Control_in = 2'bxx;
    dr = 3'bxxx;
  endtask

  initial begin
    reset = 1'b0;
    enable_writeback = 1'b0;
    W_Control_in = 2'd0;
    aluout = 16'h0; pcout = 16'h0; memout = 16'h0;
    dr = 3'd0; sr1 = 3'd0; sr2 = 3'd0;
    #2;
    check("reset_state", 3'd0, 3'd7, 16'h0000, 16'h0000, 3'b000);
    reset = 1'b1;
    @(posedge clk); #1;

    do_write(2'd0, 16'h8001, 16'h1111, 16'h2222, 3'd5);
    check("alu_write_neg", 3'd5, 3'd0, 16'h8001, 16'h0000, 3'b100);

    do_write(2'd1, 16'h1234, 16'h0000, 16'h4321, 3'd2);
    check("mem_write_zero", 3'd2, 3'd5, 16'h0000, 16'h8001, 3'b010);

    do_write(2'd2, 16'h7777, 16'h5555, 16'h3005, 3'd7);
    check("pc_write_pos", 3'd7, 3'd2, 16'h3005, 16'h0000, 3'b001);

    do_write(2'd0, 16'h0042, 16'h0000, 16'h0000, 3'd1);
    check("alu_write_r1", 3'd1, 3'd7, 16'h0042, 16'h3005, 3'b001);

    // Hold: enable low, data that would otherwise flip psr to N
    enable_writeback = 1'b0;
    W_Control_in = 2'd0; aluout = 16'hFFFF; dr = 3'd1;
    @(posedge clk); #1;
    check("hold_enable_low", 3'd1, 3'd7, 16'h0042, 16'h3005, 3'b001);

    do_write(2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd1);
    check("reserved_sel", 3'd1, 3'd5, 16'h0042, 16'h8001, 3'b001);

    do_write(2'd0, 16'h0011, 16'h0000, 16'h0000, 3'd4);
    check("r4_setup", 3'd4, 3'd4, 16'h0011, 16'h0011, 3'b001);

    // Read-during-write: old value until the edge
    enable_writeback = 1'b1;
    W_Control_in = 2'd0; aluout = 16'h0022; dr = 3'd4;
    check("rdw_before_edge", 3'd4, 3'd4, 16'h0011, 16'h0011, 3'b001);
    enable_writeback = 1'b0;
    check("rdw_after_edge", 3'd4, 3'd4, 16'h0022, 16'h0022, 3'b001);

    do_write(2'd0, 16'h0005, 16'h0000, 16'h0000, 3'd6);
    do_write(2'd0, 16'hFFFE, 16'h0000, 16'h0000, 3'd6);
    check("back_to_back", 3'd6, 3'd4, 16'hFFFE, 16'h0022, 3'b100);

    do_write(2'd0, 16'h0007, 16'h0000, 16'h0000, 3'd0);
    check("r0_write", 3'd0, 3'd6, 16'h0007, 16'hFFFE, 3'b001);
    do_write(2'd1, 16'h0001, 16'h0000, 16'h0001, 3'd0);
    check("r0_zero_psr", 3'd0, 3'd0, 16'h0000, 16'h0000, 3'b010);

    do_write(2'd0, 16'h1234, 16'h0000, 16'h0000, 3'd3);
    check("r3_before_reset", 3'd3, 3'd7, 16'h1234, 16'h3005, 3'b001);

    // Asynchronous reset: the next sample precedes any rising edge
    reset = 1'b0;
    check("async_reset_r3", 3'd3, 3'd5, 16'h0000, 16'h0000, 3'b000);
    check("async_reset_rest", 3'd7, 3'd6, 16'h0000, 16'h0000, 3'b000);
    reset = 1'b1;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_writeback.md
Name: lc3_writeback

Overview:
- Final pipeline stage of the LC3 core; sits directly downstream of the execute stage and the memory-access path.
- Selects the writeback value from the execute ALU result, the execute PC result or the memory read data, and writes it into the 8x16 general register file.
- Updates the 3-bit NZP processor status register (PSR) on every write.
- Provides the two asynchronous register read ports (VSR1/VSR2) that the execute stage consumes, addressed by the execute stage's sr1/sr2.

Parameters:
- DATA_W, 16, register and datapath width.
- NUM_REGS, 8, number of general registers; address width is clog2(NUM_REGS) = 3.

Ports:
- clk  input  1  stage clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; asserts immediately when low, releases synchronously to clk.
- enable_writeback  input  1  qualifies register write and PSR update this cycle.
- W_Control_in  input  2  writeback source select from execute: 0 = aluout, 1 = memout, 2 = pcout, 3 = reserved.
- aluout  input  16  execute ALU result.
- pcout  input  16  execute computed PC/address (used for LEA).
- memout  input  16  data returned from memory for loads.
- dr  input  3  destination register index.
- sr1  input  3  read port 1 index (from execute).
- sr2  input  3  read port 2 index (from execute).
- VSR1  output  16  contents of R[sr1].
- VSR2  output  16  contents of R[sr2].
- psr  output  3  {N,Z,P} of the last written value.

Behaviour:
- Reset (reset low, asynchronous): R0..R7 = 16'h0000 and psr = 3'b000. VSR1/VSR2 therefore read 16'h0000. reset low overrides enable_writeback in the same cycle.
- Source mux (combinational): DR_in = aluout when W_Control_in = 0, memout when 1, pcout when 2. When W_Control_in = 3, no write occurs and psr holds.
- Write (posedge clk, reset high, enable_writeback = 1, W_Control_in != 3):
  - R[dr] <= DR_in.
  - psr <= 3'b100 if DR_in[15] = 1; 3'b010 if DR_in = 0; 3'b001 otherwise.
  - Latency: 1 cycle. The new value is visible on VSR1/VSR2 and psr immediately after the edge.
- Hold: when enable_writeback = 0, all registers and psr hold, regardless of other inputs.
- Reads: VSR1 = R[sr1] and VSR2 = R[sr2], purely combinational with no clock latency.
- Read-during-write in the same cycle (sr1 or sr2 == dr while enable_writeback = 1): the read returns the OLD value until the edge. There is no write-through; forwarding is the execute stage's bypass responsibility.
- sr1 == sr2: both ports return the same register value.
- Every write updates psr, including writes to R0; there is no special handling of R0.
- Back-to-back writes to the same dr: the last write wins, and psr reflects the latest write.
- X on W_Control_in or dr while enable_writeback = 0: no effect on state.

Decomposition:
- Shared package lc3_pkg: typedef word_t (logic [15:0]), reg_idx_t (logic [2:0]), and enum wb_sel_e {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2, WB_RSVD = 2'd3}. Also the PSR encoding constants PSR_N = 3'b100, PSR_Z = 3'b010, PSR_P = 3'b001. The same package is shared with the execute and controller blocks.
- One sub-module: lc3_reg_file, the 8x16 array with one synchronous write port, two asynchronous read ports and asynchronous active-low clear. The source mux and PSR logic stay in lc3_writeback.

Test Plan:
- Reset: drive reset low mid-operation after writing R3 = 16'h1234 -> R3 and all other registers read 16'h0000 immediately, and psr = 3'b000 without waiting for a clk edge.
- ALU write: enable = 1, W_Control_in = 0, aluout = 16'h8001, dr = 5 -> after the edge, VSR1 (sr1 = 5) = 16'h8001 and psr = 3'b100.
- Memory / PC select:
  - W_Control_in = 1, memout = 16'h0000, dr = 2 -> R2 = 0, psr = 3'b010.
  - Then W_Control_in = 2, pcout = 16'h3005, dr = 7 -> R7 = 16'h3005, psr = 3'b001.
- Hold / reserved:
  - enable = 0 with aluout = 16'hFFFF, dr = 1 -> R1 and psr unchanged.
  - enable = 1 with W_Control_in = 3 -> no register changes, psr unchanged.
- Read-during-write: R4 = 16'h0011, then write 16'h0022 to dr = 4 with sr1 = sr2 = 4 -> VSR1 = VSR2 = 16'h0011 before the edge and 16'h0022 after it.
- Back-to-back: consecutive cycles write dr = 6 with 16'h0005 then 16'hFFFE -> R6 = 16'hFFFE, psr = 3'b100.
